// File: rtl/csi2_frame_controller.sv
`timescale 1ns/1ps
// csi2_frame_controller
// Turns the CSI-2 receiver packet stream of one virtual channel into frame and
// line timing, a registered pixel stream, line/frame counters and sticky
// protocol, length and line-count error flags.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   virtual_channel, word_count, image_data_type, image_data,
//   image_data_enable, interrupt   receiver packet interface
//   clear_errors           synchronous clear of the sticky error flags
//   frame_valid, line_valid, pixel_data, pixel_enable   timing / pixel stream
//   line_count, frame_count, frame_done                 counters / FE pulse
//   err_sequence, err_length, err_line_count            sticky errors
module csi2_frame_controller #(
   parameter int unsigned VIRTUAL_CHANNEL = 0,
   parameter int unsigned EXPECTED_LINES  = 0,
   parameter logic [15:0] MAX_WORD_COUNT  = 16'd8192
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  virtual_channel,
   input  logic [15:0] word_count,
   input  logic [5:0]  image_data_type,
   input  logic [31:0] image_data,
   input  logic        image_data_enable,
   input  logic        interrupt,
   input  logic        clear_errors,
   output logic        frame_valid,
   output logic        line_valid,
   output logic [31:0] pixel_data,
   output logic        pixel_enable,
   output logic [15:0] line_count,
   output logic [15:0] frame_count,
   output logic        frame_done,
   output logic        err_sequence,
   output logic        err_length,
   output logic        err_line_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FRAME = 2'd1;
   localparam logic [1:0] ST_LINE  = 2'd2;

   localparam logic [5:0]  DT_FS = 6'h00;
   localparam logic [5:0]  DT_FE = 6'h01;
   localparam logic [5:0]  DT_LS = 6'h02;
   localparam logic [5:0]  DT_LE = 6'h03;
   localparam logic [1:0]  VC        = VIRTUAL_CHANNEL[1:0];
   localparam logic [15:0] EXP_LINES = EXPECTED_LINES[15:0];

   logic [1:0]  state_q, state_d, mid_state;
   logic        int_prev_q;
   logic [15:0] wc_q, wc_d;
   logic [15:0] beats_q, beats_d, beats_now;
   logic [16:0] exp_beats;
   logic        frame_valid_q, frame_valid_d;
   logic        line_valid_q, line_valid_d;
   logic [31:0] pix_data_q, pix_data_d;
   logic        pix_en_q, pix_en_d;
   logic [15:0] line_count_q, line_count_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        frame_done_q, frame_done_d;
   logic        err_seq_q, err_len_q, err_lc_q;
   logic        set_seq, set_len, set_lc;
   logic        hdr_evt, is_long;

   // Header = rising edge of interrupt on our channel; other channels are
   // never seen, so their payload enables fall outside LINE and are dropped.
   assign hdr_evt   = interrupt && !int_prev_q && (virtual_channel == VC);
   assign is_long   = (image_data_type[5:4] != 2'b00);
   assign exp_beats = ({1'b0, wc_q} + 17'd3) >> 2;

   always_comb begin
      state_d       = state_q;
      mid_state     = state_q;
      wc_d          = wc_q;
      beats_d       = beats_q;
      beats_now     = beats_q;
      frame_valid_d = frame_valid_q;
      line_valid_d  = line_valid_q;
      pix_data_d    = pix_data_q;
      pix_en_d      = 1'b0;
      line_count_d  = line_count_q;
      frame_count_d = frame_count_q;
      frame_done_d  = 1'b0;
      set_seq       = 1'b0;
      set_len       = 1'b0;
      set_lc        = 1'b0;

      if (state_q == ST_LINE) begin
         if (image_data_enable) begin
            pix_data_d = image_data;
            pix_en_d   = 1'b1;
            if (beats_q != 16'hFFFF)
               beats_now = beats_q + 16'd1;
         end
         beats_d = beats_now;
         // End of payload (or an unexpected new header): close the line and
         // count it even if the beat count is wrong.
         if (!interrupt || hdr_evt) begin
            line_valid_d = 1'b0;
            if (line_count_q != 16'hFFFF)
               line_count_d = line_count_q + 16'd1;
            if ({1'b0, beats_now} != exp_beats)
               set_len = 1'b1;
            if (hdr_evt)
               set_seq = 1'b1;
            state_d   = ST_FRAME;
            mid_state = ST_FRAME;
         end
      end

      // Header processing sees the state after any line close this cycle.
      if (hdr_evt) begin
         if (mid_state == ST_IDLE) begin
            if (image_data_type == DT_FS) begin
               state_d       = ST_FRAME;
               frame_valid_d = 1'b1;
               line_count_d  = 16'd0;
            end else if (is_long || image_data_type == DT_FE ||
                         image_data_type == DT_LS || image_data_type == DT_LE) begin
               set_seq = 1'b1;
            end
         end else if (mid_state == ST_FRAME) begin
            if (is_long) begin
               if (word_count != 16'd0 && word_count <= MAX_WORD_COUNT) begin
                  state_d      = ST_LINE;
                  line_valid_d = 1'b1;
                  wc_d         = word_count;
                  beats_d      = 16'd0;
               end else begin
                  set_len = 1'b1;
               end
            end else if (image_data_type == DT_FE) begin
               state_d       = ST_IDLE;
               frame_valid_d = 1'b0;
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               if (EXPECTED_LINES != 0 && line_count_d != EXP_LINES)
                  set_lc = 1'b1;
            end else if (image_data_type == DT_FS) begin
               set_seq      = 1'b1;
               line_count_d = 16'd0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         int_prev_q    <= 1'b0;
         wc_q          <= 16'd0;
         beats_q       <= 16'd0;
         frame_valid_q <= 1'b0;
         line_valid_q  <= 1'b0;
         pix_data_q    <= 32'd0;
         pix_en_q      <= 1'b0;
         line_count_q  <= 16'd0;
         frame_count_q <= 16'd0;
         frame_done_q  <= 1'b0;
         err_seq_q     <= 1'b0;
         err_len_q     <= 1'b0;
         err_lc_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         int_prev_q    <= interrupt;
         wc_q          <= wc_d;
         beats_q       <= beats_d;
         frame_valid_q <= frame_valid_d;
         line_valid_q  <= line_valid_d;
         pix_data_q    <= pix_data_d;
         pix_en_q      <= pix_en_d;
         line_count_q  <= line_count_d;
         frame_count_q <= frame_count_d;
         frame_done_q  <= frame_done_d;
         // A new error set on the same edge as a clear wins.
         err_seq_q     <= set_seq || (err_seq_q && !clear_errors);
         err_len_q     <= set_len || (err_len_q && !clear_errors);
         err_lc_q      <= set_lc  || (err_lc_q  && !clear_errors);
      end
   end

   assign frame_valid    = frame_valid_q;
   assign line_valid     = line_valid_q;
   assign pixel_data     = pix_data_q;
   assign pixel_enable   = pix_en_q;
   assign line_count     = line_count_q;
   assign frame_count    = frame_count_q;
   assign frame_done     = frame_done_q;
   assign err_sequence   = err_seq_q;
   assign err_length     = err_len_q;
   assign err_line_count = err_lc_q;

endmodule

// File: tb/tb_csi2_frame_controller.sv
`timescale 1ns/1ps
module tb_csi2_frame_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  virtual_channel;
   logic [15:0] word_count;
   logic [5:0]  image_data_type;
   logic [31:0] image_data;
   logic        image_data_enable;
   logic        interrupt;
   logic        clear_errors;

   logic        frame_valid, line_valid, pixel_enable, frame_done;
   logic [31:0] pixel_data;
   logic [15:0] line_count, frame_count;
   logic        err_sequence, err_length, err_line_count;

   logic        fv3, lv3, pe3, fd3, es3, el3, elc3;
   logic [31:0] pd3;
   logic [15:0] lc3, fc3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   csi2_frame_controller #(.VIRTUAL_CHANNEL(0), .EXPECTED_LINES(2), .MAX_WORD_COUNT(16'd8192)) u_dut (
      .clock(clock), .reset(reset), .virtual_channel(virtual_channel),
      .word_count(word_count), .image_data_type(image_data_type),
      .image_data(image_data), .image_data_enable(image_data_enable),
      .interrupt(interrupt), .clear_errors(clear_errors),
      .frame_valid(frame_valid), .line_valid(line_valid),
      .pixel_data(pixel_data), .pixel_enable(pixel_enable),
      .line_count(line_count), .frame_count(frame_count),
      .frame_done(frame_done), .err_sequence(err_sequence),
      .err_length(err_length), .err_line_count(err_line_count)
   );

   csi2_frame_controller #(.VIRTUAL_CHANNEL(0), .EXPECTED_LINES(3), .MAX_WORD_COUNT(16'd8192)) u_dut3 (
      .clock(clock), .reset(reset), .virtual_channel(virtual_channel),
      .word_count(word_count), .image_data_type(image_data_type),
      .image_data(image_data), .image_data_enable(image_data_enable),
      .interrupt(interrupt), .clear_errors(clear_errors),
      .frame_valid(fv3), .line_valid(lv3),
      .pixel_data(pd3), .pixel_enable(pe3),
      .line_count(lc3), .frame_count(fc3),
      .frame_done(fd3), .err_sequence(es3),
      .err_length(el3), .err_line_count(elc3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("vector %0d %s: observed %0h expected %0h", n_vec, tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_short(input logic [1:0] vc, input logic [5:0] dt);
      virtual_channel = vc;
      image_data_type = dt;
      word_count      = 16'd0;
      interrupt       = 1'b1;
      tick();
      interrupt = 1'b0;
   endtask

   task automatic idle_tick();
      interrupt = 1'b0;
      tick();
   endtask

   // Long packet with up to two payload words; acc says whether the
   // controller should stream it out.
   task automatic send_long(input logic [1:0] vc, input logic [15:0] wc, input int n,
                            input logic [31:0] w0, input logic [31:0] w1, input bit acc);
      virtual_channel = vc;
      image_data_type = 6'h2A;
      word_count      = wc;
      interrupt       = 1'b1;
      tick();
      check("line_valid_hdr", {31'd0, line_valid}, {31'd0, acc});
      word_count      = 16'hFFFF;   // must be ignored after the header
      image_data_type = 6'h01;
      for (int i = 0; i < n; i++) begin
         image_data        = (i == 0) ? w0 : w1;
         image_data_enable = 1'b1;
         tick();
         check("pixel_enable", {31'd0, pixel_enable}, {31'd0, acc});
         if (acc) check("pixel_data", pixel_data, (i == 0) ? w0 : w1);
      end
      image_data_enable = 1'b0;
      interrupt         = 1'b0;
      tick();
      check("line_valid_end", {31'd0, line_valid}, 32'd0);
      check("pixel_enable_end", {31'd0, pixel_enable}, 32'd0);
   endtask

   task automatic pulse_clear();
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      virtual_channel = 2'd0; word_count = 16'd0; image_data_type = 6'h3F;
      image_data = 32'd0; image_data_enable = 1'b0; interrupt = 1'b0; clear_errors = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
      check("reset_counts", {line_count, frame_count}, 32'd0);
      check("reset_errors", {29'd0, err_sequence, err_length, err_line_count}, 32'd0);

      // 1: clean two-line frame on VC0
      send_short(2'd0, 6'h00);
      check("t1_frame_valid", {31'd0, frame_valid}, 32'd1);
      check("t1_line_count0", {16'd0, line_count}, 32'd0);
      idle_tick();
      send_long(2'd0, 16'd8, 2, 32'hFEE1DEAD, 32'h0D15EA5E, 1'b1);
      check("t1_line_count1", {16'd0, line_count}, 32'd1);
      send_long(2'd0, 16'd8, 2, 32'hFEE1DEAD, 32'h0D15EA5E, 1'b1);
      check("t1_line_count2", {16'd0, line_count}, 32'd2);
      send_short(2'd0, 6'h01);
      check("t1_frame_done", {31'd0, frame_done}, 32'd1);
      check("t1_frame_count", {16'd0, frame_count}, 32'd1);
      check("t1_frame_valid_off", {31'd0, frame_valid}, 32'd0);
      idle_tick();
      check("t1_frame_done_pulse", {31'd0, frame_done}, 32'd0);
      check("t1_errors", {29'd0, err_sequence, err_length, err_line_count}, 32'd0);

      // 2: long packet outside a frame
      send_long(2'd0, 16'd8, 2, 32'h11111111, 32'h22222222, 1'b0);
      check("t2_err_sequence", {31'd0, err_sequence}, 32'd1);
      check("t2_frame_valid", {31'd0, frame_valid}, 32'd0);
      check("t2_line_count_kept", {16'd0, line_count}, 32'd2);
      pulse_clear();
      check("t2_clear", {31'd0, err_sequence}, 32'd0);

      // 3: short payload, zero and oversize word counts
      send_short(2'd0, 6'h00);
      idle_tick();
      send_long(2'd0, 16'd8, 1, 32'hCAFEF00D, 32'h0, 1'b1);
      check("t3_err_length", {31'd0, err_length}, 32'd1);
      check("t3_line_count", {16'd0, line_count}, 32'd1);
      pulse_clear();
      check("t3_clear", {31'd0, err_length}, 32'd0);
      send_long(2'd0, 16'd0, 1, 32'h33333333, 32'h0, 1'b0);
      check("t3_wc0_err", {31'd0, err_length}, 32'd1);
      pulse_clear();
      send_long(2'd0, 16'd8193, 1, 32'h44444444, 32'h0, 1'b0);
      check("t3_wcmax_err", {31'd0, err_length}, 32'd1);
      check("t3_line_count_kept", {16'd0, line_count}, 32'd1);
      send_short(2'd0, 6'h01);
      check("t3_err_line_count", {31'd0, err_line_count}, 32'd1);
      check("t3_frame_count", {16'd0, frame_count}, 32'd2);
      idle_tick();
      pulse_clear();
      check("t3_clear_all", {29'd0, err_sequence, err_length, err_line_count}, 32'd0);

      // 4: VC1 frame interleaved with a VC0 frame
      send_short(2'd0, 6'h00); idle_tick();
      send_short(2'd1, 6'h00); idle_tick();
      send_long(2'd0, 16'd5, 2, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
      send_long(2'd1, 16'd4, 1, 32'hBADBADBA, 32'h0, 1'b0);
      send_short(2'd1, 6'h01);
      check("t4_vc1_fe_no_done", {31'd0, frame_done}, 32'd0);
      check("t4_vc1_fe_count", {16'd0, frame_count}, 32'd2);
      check("t4_frame_valid", {31'd0, frame_valid}, 32'd1);
      idle_tick();
      send_long(2'd0, 16'd4, 1, 32'h12345678, 32'h0, 1'b1);
      send_short(2'd0, 6'h01);
      check("t4_frame_count", {16'd0, frame_count}, 32'd3);
      check("t4_line_count", {16'd0, line_count}, 32'd2);
      check("t4_errors", {29'd0, err_sequence, err_length, err_line_count}, 32'd0);
      idle_tick();
      pulse_clear();   // u_dut3 expected 3 lines above

      // 5: line-count mismatch with EXPECTED_LINES=3, then FS without FE
      check("t5_pre_elc3", {31'd0, elc3}, 32'd0);
      send_short(2'd0, 6'h00); idle_tick();
      send_long(2'd0, 16'd8, 2, 32'h01020304, 32'h05060708, 1'b1);
      send_long(2'd0, 16'd8, 2, 32'h090A0B0C, 32'h0D0E0F10, 1'b1);
      send_short(2'd0, 6'h01);
      check("t5_err_line_count3", {31'd0, elc3}, 32'd1);
      check("t5_frame_count3", {16'd0, fc3}, 32'd4);
      check("t5_err_line_count2", {31'd0, err_line_count}, 32'd0);
      idle_tick();
      send_short(2'd0, 6'h00); idle_tick();
      send_long(2'd0, 16'd4, 1, 32'hDEADBEEF, 32'h0, 1'b1);
      check("t5_lc_before_fs", {16'd0, line_count}, 32'd1);
      send_short(2'd0, 6'h00);
      check("t5_err_sequence", {31'd0, err_sequence}, 32'd1);
      check("t5_line_count_reset", {16'd0, line_count}, 32'd0);
      check("t5_frame_valid", {31'd0, frame_valid}, 32'd1);
      idle_tick();

      // 6: asynchronous reset in the middle of a line
      virtual_channel = 2'd0; image_data_type = 6'h2A; word_count = 16'd8;
      interrupt = 1'b1;
      tick();
      image_data = 32'h77777777; image_data_enable = 1'b1;
      tick();
      check("t6_pre_reset_pe", {31'd0, pixel_enable}, 32'd1);
      #2;
      reset = 1'b1; interrupt = 1'b0; image_data_enable = 1'b0;
      #1;
      check("t6_async_flags", {23'd0, frame_valid, line_valid, pixel_enable, frame_done,
                               err_sequence, err_length, err_line_count, 2'b00}, 32'd0);
      check("t6_async_pixel", pixel_data, 32'd0);
      check("t6_async_counts", {line_count, frame_count}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      send_short(2'd0, 6'h00);
      check("t6_fs_frame_valid", {31'd0, frame_valid}, 32'd1);
      check("t6_fs_line_count", {16'd0, line_count}, 32'd0);
      check("t6_fs_errors", {29'd0, err_sequence, err_length, err_line_count}, 32'd0);
      idle_tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/csi2_frame_controller.md
Name: csi2_frame_controller

Overview:
Sequences the packet stream produced by the CSI-2 camera receiver into frame and line timing for downstream image logic. It filters one virtual channel and tracks Frame Start/End and Line Start/End short packets. It gates long-packet payload words into a registered pixel stream and maintains line/frame counters. It also flags protocol-sequence, payload-length and line-count errors.

Parameters:
VIRTUAL_CHANNEL, 0, channel (0-3) this controller accepts; packets on other channels are ignored entirely.
EXPECTED_LINES, 0, lines per frame; 0 disables line-count checking.
MAX_WORD_COUNT, 16'd8192, largest legal long-packet word_count; larger values are a length error and the payload is dropped.

Ports:
clock  input  1  receiver byte clock; all logic on its rising edge.
reset  input  1  asynchronous, active-high reset.
virtual_channel  input  2  channel of current packet (receiver output).
word_count  input  16  word count / short-packet data field of current packet.
image_data_type  input  6  data type of current packet.
image_data  input  32  payload bytes, byte 0 in [7:0].
image_data_enable  input  1  image_data holds a valid 4-byte payload word.
interrupt  input  1  high from header decode to end of packet; a 0->1 edge marks a new header.
frame_valid  output  1  high from accepted Frame Start until Frame End.
line_valid  output  1  high while an accepted image long packet is streaming.
pixel_data  output  32  registered copy of image_data.
pixel_enable  output  1  pixel_data valid.
line_count  output  16  image lines completed in current frame.
frame_count  output  16  Frame End packets accepted since reset; wraps 0xFFFF->0.
frame_done  output  1  one-cycle pulse on accepted Frame End.
err_sequence  output  1  sticky protocol-order error.
err_length  output  1  sticky payload-length error.
err_line_count  output  1  sticky line-count mismatch.
clear_errors  input  1  synchronous clear of all three sticky error flags.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; the stored previous-interrupt value is 0.
- Header event: interrupt==1 while the previous cycle's interrupt==0. Headers with virtual_channel!=VIRTUAL_CHANNEL are ignored, including their payload enables.
- Types: 0x00 FS, 0x01 FE, 0x02 LS, 0x03 LE, 0x04-0x07 ignored, 0x08-0x0F generic short (ignored). Types >=0x10 are long packets.
- States:
  - IDLE:
    - FS -> FRAME; frame_valid=1, line_count=0.
    - FE, LS, LE or long packet -> err_sequence=1; stay IDLE; payload dropped.
  - FRAME:
    - Long packet with word_count in 1..MAX_WORD_COUNT -> LINE; line_valid=1.
    - Long packet with word_count 0 or >MAX_WORD_COUNT -> err_length=1; stay FRAME; payload dropped.
    - FE -> IDLE; frame_valid=0; frame_done pulse; frame_count+1. If EXPECTED_LINES!=0 and line_count!=EXPECTED_LINES, err_line_count=1.
    - FS -> err_sequence=1; restart frame (line_count=0, stay FRAME).
    - LS/LE -> accepted, no effect.
  - LINE:
    - Each image_data_enable -> pixel_data<=image_data, pixel_enable=1 next cycle (latency 1); beat counter+1.
    - interrupt falls -> FRAME; line_valid=0; line_count+1 (saturates at 0xFFFF).
    - If beats != (word_count+3)>>2 at that point, err_length=1; the line is still counted.
    - A new header while in LINE (interrupt stayed high) -> err_sequence=1; close the line as above, then process the header from FRAME.
- word_count and image_data_type are latched at the header edge; later changes during a packet are ignored.
- pixel_enable only asserts in LINE. Beats beyond the expected count still pass through but set err_length.
- frame_done and the FE error update coincide with the FE header cycle+1.
- clear_errors takes effect at the same edge unless a new error is set that edge; set wins.
- Asynchronous reset mid-frame or mid-line returns to IDLE immediately; no frame_done is issued.

Test Plan:
1. VC0: FS, 2 lines each word_count=8 with 2 enables (0xFEE1DEAD, 0x0D15EA5E), then FE; EXPECTED_LINES=2.
   -> pixel_data follows each word 1 cycle later; line_count=2; frame_count=1; one frame_done pulse; no errors.
2. Long packet word_count=8 before any FS.
   -> err_sequence=1; pixel_enable never asserts; state IDLE.
3. Inside a frame, word_count=8 but only 1 enable before interrupt falls.
   -> err_length=1; line_count increments to 1.
   Then assert clear_errors -> err_length=0.
4. Frame on VC1 interleaved with a VC0 frame.
   -> only VC0 data on pixel_data; VC1 FS/FE cause no errors or counter changes.
5. EXPECTED_LINES=3; frame with 2 lines then FE.
   -> err_line_count=1; frame_count increments.
   Second FS without FE -> err_sequence=1, line_count reset to 0.
6. Assert reset while in LINE mid-payload.
   -> all outputs 0 immediately; next FS starts a clean frame with line_count=0.
